universal_shift_reg: RTL and testbench
======================================

Name: universal_shift_reg

Overview:
- WIDTH-bit universal shift register: hold, shift right, shift left and parallel load, selected by a 2-bit mode.
- Each storage bit is one D flip-flop cell; the block is the stage directly downstream of the single D flip-flop and consumes its Q/Qb behaviour.
- A shift counter and a `full` flag mark when WIDTH serial bits have been captured since the last load or reset.
- Sits between serial input logic and a parallel consumer; also feeds serial out to the next register.

Parameters:
- WIDTH, 4, number of storage bits (>= 2).
- CNT_W, $clog2(WIDTH+1), width of the shift counter (derived; do not override).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_r  input  1  serial input entering the MSB on a right shift.
- sin_l  input  1  serial input entering the LSB on a left shift.
- pdata  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- qb  output  WIDTH  bitwise complement of q; always equals ~q.
- sout_r  output  1  q[0], combinational.
- sout_l  output  1  q[WIDTH-1], combinational.
- shift_cnt  output  CNT_W  shifts since the last load or reset; saturates at WIDTH.
- full  output  1  high iff shift_cnt == WIDTH.

Behaviour:
- Reset: rst=1 at a rising edge sets q=0, qb=all ones, shift_cnt=0, full=0. Reset overrides mode. Asserting rst mid-sequence discards the partial capture.
- Latency: one cycle. Edge n samples mode/sin/pdata; q updates after edge n. Outputs are registered except sout_r, sout_l, full and qb.
- Hold (00): q and shift_cnt unchanged.
- Shift right (01): q <= {sin_r, q[WIDTH-1:1]}; shift_cnt increments, saturating at WIDTH.
- Shift left (10): q <= {q[WIDTH-2:0], sin_l}; shift_cnt increments, saturating at WIDTH.
- Load (11): q <= pdata; shift_cnt <= 0.
- Counter: mixing left and right shifts counts each shift. Once full, further shifts keep full=1 and shift_cnt=WIDTH. Only load or reset clears the counter.
- Serial chaining: sout_r and sout_l show the pre-edge value, so two instances chained on one clock behave as one 2*WIDTH-bit register.
- Each bit's D is selected combinationally by a per-bit 4:1 mux; there is no gating of clk.

Optional Feature:
- Macro: USR_ROTATE_EN.
- Defined: shift right rotates, q <= {q[0], q[WIDTH-1:1]}; shift left rotates, q <= {q[WIDTH-2:0], q[WIDTH-1]}. sin_r and sin_l are ignored. Counter and full behave the same.
- Not defined: serial inputs are used exactly as described in Behaviour.

Decomposition:
- Package usr_pkg:
  - enum mode_e: MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
  - Default WIDTH constant.
- Sub-module d_ff_cell: ports clk, rst, d, q, qb. Synchronous active-high reset to q=0, qb=1. Instantiated WIDTH times via generate.
- Mux select and counter logic live in the top module.

Test Plan (WIDTH=4):
- Reset: rst=1 for 1 cycle with mode=11, pdata=4'hF → q=0000, qb=1111, shift_cnt=0, full=0.
- Load then hold: mode=11, pdata=4'b1010, 1 edge; then mode=00 for 3 edges → q=1010, qb=0101 throughout hold, shift_cnt=0.
- Right fill: from q=0, mode=01, sin_r sequence 1,0,1,1 over 4 edges → q=1101, shift_cnt steps 1,2,3,4, full=1 after the 4th edge; a 5th shift keeps shift_cnt=4 and full=1.
- Left shift/serial out: load 4'b1001, then mode=10, sin_l=0 for 2 edges → sout_l reads 1 then 0 before each edge; q=0100.
- Reset mid-fill: 2 right shifts, then rst=1 together with mode=01 → q=0000, shift_cnt=0, and the next shift gives shift_cnt=1.
- USR_ROTATE_EN: load 4'b0001, mode=01 for 4 edges with sin_r=1 → q goes 1000, 0100, 0010, 0001; sin_r has no effect; full=1.

Source files
------------

// File: rtl/universal_shift_reg_pkg.sv
// Shared types and constants for the universal shift register slice.
// Holds the operation-mode encoding and the default register width.
package usr_pkg;

    // Default number of storage bits.
    localparam int DEFAULT_WIDTH = 4;

    // Operation select encoding.
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage : usr_pkg

// File: rtl/universal_shift_reg_d_ff_cell.sv
// Single D flip-flop storage cell with synchronous active-high reset.
// q is the stored bit; qb is its complement (1 while in reset).
module d_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic qb
);

    logic q_r;

    // Capture d on every rising edge; reset forces the stored bit low.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= 1'b0;
        end else begin
            q_r <= d;
        end
    end

    assign q  = q_r;
    assign qb = ~q_r;

endmodule : d_ff_cell

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: hold, shift right, shift left and
// parallel load. A saturating shift counter and a full flag indicate that
// WIDTH serial bits have been captured since the last load or reset.
// Optional build macro: USR_ROTATE_EN (shifts rotate; sin_r/sin_l ignored).
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             full
);

    mode_e            mode_s;
    logic [WIDTH-1:0] d_s;
    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] qb_s;
    logic             shr_in_s;
    logic             shl_in_s;
    logic [CNT_W-1:0] cnt_r;

    assign mode_s = mode_e'(mode);

`ifdef USR_ROTATE_EN
    // Rotation: the bit leaving one end re-enters at the other.
    assign shr_in_s = q_s[0];
    assign shl_in_s = q_s[WIDTH-1];
`else
    assign shr_in_s = sin_r;
    assign shl_in_s = sin_l;
`endif

    // Per-bit next-state select: each bit picks itself, its upper or lower
    // neighbour, or the parallel input according to the mode.
    always_comb begin
        d_s = q_s;
        case (mode_s)
            MODE_HOLD: d_s = q_s;
            MODE_SHR:  d_s = {shr_in_s, q_s[WIDTH-1:1]};
            MODE_SHL:  d_s = {q_s[WIDTH-2:0], shl_in_s};
            MODE_LOAD: d_s = pdata;
            default:   d_s = q_s;
        endcase
    end

    // One storage cell per bit; clock is never gated, hold recirculates q.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        d_ff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .d   (d_s[i]),
            .q   (q_s[i]),
            .qb  (qb_s[i])
        );
    end

    // Count shifts in either direction, saturating at WIDTH; load clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (mode_s)
                MODE_SHR, MODE_SHL: begin
                    if (cnt_r != CNT_W'(WIDTH)) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                MODE_LOAD: cnt_r <= {CNT_W{1'b0}};
                MODE_HOLD: cnt_r <= cnt_r;
                default:   cnt_r <= cnt_r;
            endcase
        end
    end

    // Serial outputs show the pre-edge contents so instances chain cleanly.
    assign q         = q_s;
    assign qb        = qb_s;
    assign sout_r    = q_s[0];
    assign sout_l    = q_s[WIDTH-1];
    assign shift_cnt = cnt_r;
    assign full      = (cnt_r == CNT_W'(WIDTH));

endmodule : universal_shift_reg

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=4): directed scenarios
// followed by randomized traffic, all compared against an arithmetic model.
module tb_universal_shift_reg;
    import usr_pkg::*;

    localparam int W    = 4;
    localparam int CW   = $clog2(W + 1);
    localparam int MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          sin_r;
    logic          sin_l;
    logic [W-1:0]  pdata;
    logic [W-1:0]  q;
    logic [W-1:0]  qb;
    logic          sout_r;
    logic          sout_l;
    logic [CW-1:0] shift_cnt;
    logic          full;

    int n_vec = 0;
    int n_err = 0;
    int ref_q = 0;
    int ref_cnt = 0;
    bit ref_valid = 1'b0;

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .pdata     (pdata),
        .q         (q),
        .qb        (qb),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .shift_cnt (shift_cnt),
        .full      (full)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, check serial outs before the edge and
    // all registered state after it.
    task automatic step(input logic r, input logic [1:0] m, input logic sr,
                        input logic sl, input logic [W-1:0] pd);
        int in_r;
        int in_l;
        rst = r; mode = m; sin_r = sr; sin_l = sl; pdata = pd;
        #1;
        if (ref_valid) begin
            check("sout_r", {31'd0, sout_r}, ref_q & 1);
            check("sout_l", {31'd0, sout_l}, (ref_q >> (W - 1)) & 1);
        end
        @(posedge clk);
`ifdef USR_ROTATE_EN
        in_r = ref_q & 1;
        in_l = (ref_q >> (W - 1)) & 1;
`else
        in_r = int'(sr);
        in_l = int'(sl);
`endif
        if (r) begin
            ref_q = 0;
            ref_cnt = 0;
        end else if (m == 2'b01) begin
            ref_q = (ref_q >> 1) | (in_r << (W - 1));
            ref_cnt = (ref_cnt < W) ? ref_cnt + 1 : W;
        end else if (m == 2'b10) begin
            ref_q = ((ref_q << 1) | in_l) & MASK;
            ref_cnt = (ref_cnt < W) ? ref_cnt + 1 : W;
        end else if (m == 2'b11) begin
            ref_q = int'(pd);
            ref_cnt = 0;
        end
        ref_valid = 1'b1;
        #1;
        check("q", {28'd0, q}, ref_q);
        check("qb", {28'd0, qb}, (~ref_q) & MASK);
        check("shift_cnt", {29'd0, shift_cnt}, ref_cnt);
        check("full", {31'd0, full}, (ref_cnt == W) ? 1 : 0);
    endtask

    initial begin
        // Reset overriding a load of all ones.
        step(1'b1, 2'b11, 1'b0, 1'b0, 4'hF);
        check("rst_q", {28'd0, q}, 32'h0);
        check("rst_qb", {28'd0, qb}, 32'hF);

        // Load then hold.
        step(1'b0, 2'b11, 1'b0, 1'b0, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b00, 1'b1, 1'b1, 4'h5);
            check("hold_q", {28'd0, q}, 32'hA);
            check("hold_qb", {28'd0, qb}, 32'h5);
        end

        // Right fill from zero, then one extra shift past saturation.
        step(1'b1, 2'b00, 1'b0, 1'b0, 4'h0);
        step(1'b0, 2'b01, 1'b1, 1'b0, 4'h0);
        step(1'b0, 2'b01, 1'b0, 1'b0, 4'h0);
        step(1'b0, 2'b01, 1'b1, 1'b0, 4'h0);
        step(1'b0, 2'b01, 1'b1, 1'b0, 4'h0);
`ifndef USR_ROTATE_EN
        check("fill_q", {28'd0, q}, 32'hD);
`endif
        check("fill_full", {31'd0, full}, 32'h1);
        step(1'b0, 2'b01, 1'b0, 1'b0, 4'h0);
        check("sat_cnt", {29'd0, shift_cnt}, 32'h4);

        // Left shift with serial out.
        step(1'b0, 2'b11, 1'b0, 1'b0, 4'b1001);
        step(1'b0, 2'b10, 1'b0, 1'b0, 4'h0);
        step(1'b0, 2'b10, 1'b0, 1'b0, 4'h0);
`ifndef USR_ROTATE_EN
        check("shl_q", {28'd0, q}, 32'h4);
`endif

        // Reset in the middle of a fill.
        step(1'b0, 2'b01, 1'b1, 1'b0, 4'h0);
        step(1'b0, 2'b01, 1'b1, 1'b0, 4'h0);
        step(1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
        check("midrst_cnt", {29'd0, shift_cnt}, 32'h0);
        step(1'b0, 2'b01, 1'b1, 1'b0, 4'h0);
        check("after_rst_cnt", {29'd0, shift_cnt}, 32'h1);

        // Rotation pattern (serial inputs used unless rotation is built in).
        step(1'b0, 2'b11, 1'b0, 1'b0, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b01, 1'b1, 1'b0, 4'h0);
`ifdef USR_ROTATE_EN
            check("rot_q", {28'd0, q}, 32'h8 >> i);
`endif
        end
        check("rot_full", {31'd0, full}, 32'h1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_universal_shift_reg
